// File: rtl/clic_irq_scanner_pkg.sv
// Shared types for the CLIC interrupt scanner.
//   scan_state_e : scanner FSM states
//   scan_best_t  : running/chunk winner (found flag, source id, level),
//                  sized to the widest supported id/level; users take
//                  the low bits they need.
//   scan_cfg_ok  : true when NumSrc splits evenly into ScanWidth chunks
package clic_scan_pkg;

  localparam int unsigned MaxIdWidth    = 16;
  localparam int unsigned MaxLevelWidth = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic                     found;
    logic [MaxIdWidth-1:0]    id;
    logic [MaxLevelWidth-1:0] level;
  } scan_best_t;

  function automatic bit scan_cfg_ok(input int unsigned num_src,
                                     input int unsigned scan_width);
    return (scan_width != 0) && ((num_src % scan_width) == 0);
  endfunction

endpackage

// File: rtl/clic_chunk_max.sv
// Combinational winner selection over one chunk of ScanWidth sources.
//   pending_i/enable_i : chunk pending and enable bits
//   level_i            : chunk levels, source i at [i*LevelWidth +: LevelWidth]
//   threshold_i        : a candidate must be strictly above this level
//   base_id_i          : global index of chunk source 0
//   best_o             : highest-level candidate, lowest index on ties
module clic_chunk_max
  import clic_scan_pkg::*;
#(
  parameter int unsigned ScanWidth  = 16,
  parameter int unsigned LevelWidth = 8,
  parameter int unsigned IdWidth    = 8
) (
  input  logic [ScanWidth-1:0]            pending_i,
  input  logic [ScanWidth-1:0]            enable_i,
  input  logic [ScanWidth*LevelWidth-1:0] level_i,
  input  logic [LevelWidth-1:0]           threshold_i,
  input  logic [IdWidth-1:0]              base_id_i,
  output scan_best_t                      best_o
);

  // Ascending walk with a strict '>' replace keeps the lowest index on ties.
  always_comb begin
    logic [LevelWidth-1:0] lvl;
    logic                  live;
    best_o = '0;
    lvl    = '0;
    live   = 1'b0;
    for (int unsigned i = 0; i < ScanWidth; i++) begin
      lvl  = LevelWidth'(level_i >> (i * LevelWidth));
      live = |((pending_i & enable_i) & (ScanWidth'(1) << i));
      if (live && (lvl > threshold_i) &&
          (!best_o.found || (MaxLevelWidth'(lvl) > best_o.level))) begin
        best_o.found = 1'b1;
        best_o.id    = MaxIdWidth'(base_id_i + IdWidth'(i));
        best_o.level = MaxLevelWidth'(lvl);
      end
    end
  end

endmodule

// File: rtl/clic_irq_scanner.sv
// CLIC interrupt selector: scans NumSrc sources ScanWidth per cycle and
// presents the highest-level pending+enabled source above threshold_i.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   scan_en_i      : scanning enabled
//   pending_i      : per-source pending bits
//   enable_i       : per-source enable bits
//   level_i        : per-source levels, source k at [k*LevelWidth +: LevelWidth]
//   threshold_i    : candidates must be strictly above this level
//   irq_valid_o    : selected interrupt available
//   irq_id_o       : selected source index
//   irq_level_o    : selected source level
//   irq_ready_i    : core claims the interrupt
//   busy_o         : a scan pass is in progress
// Optional macro CLIC_SCAN_PREEMPT_EN: keep scanning during HOLD and replace
// the presented interrupt when a pass finds a strictly higher level.
module clic_irq_scanner
  import clic_scan_pkg::*;
#(
  parameter int unsigned NumSrc     = 256,
  parameter int unsigned ScanWidth  = 16,
  parameter int unsigned LevelWidth = 8,
  parameter int unsigned IdWidth    = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scan_en_i,
  input  logic [NumSrc-1:0]            pending_i,
  input  logic [NumSrc-1:0]            enable_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  input  logic [LevelWidth-1:0]        threshold_i,
  output logic                         irq_valid_o,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  input  logic                         irq_ready_i,
  output logic                         busy_o
);

  localparam int unsigned NumChunks = NumSrc / ScanWidth;
  localparam int unsigned CntWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned ChunkLvlW = ScanWidth * LevelWidth;

  if (!scan_cfg_ok(NumSrc, ScanWidth)) begin : g_bad_cfg
    $error("clic_irq_scanner: NumSrc must be a multiple of ScanWidth");
  end
  if ((IdWidth > MaxIdWidth) || (LevelWidth > MaxLevelWidth)) begin : g_bad_width
    $error("clic_irq_scanner: IdWidth/LevelWidth exceed scan_best_t fields");
  end

  scan_state_e           state;
  logic [CntWidth-1:0]   cnt;
  scan_best_t            run_best;
  scan_best_t            chunk_best;
  scan_best_t            merged;
  int unsigned           chunk_base;
  logic                  last_chunk;
  logic                  claim;
  logic                  withdraw;
  logic                  unused_hi_bits;

  always_comb begin
    chunk_base = 32'(cnt) * ScanWidth;
  end

  clic_chunk_max #(
    .ScanWidth (ScanWidth),
    .LevelWidth(LevelWidth),
    .IdWidth   (IdWidth)
  ) u_chunk_max (
    .pending_i  (ScanWidth'(pending_i >> chunk_base)),
    .enable_i   (ScanWidth'(enable_i >> chunk_base)),
    .level_i    (ChunkLvlW'(level_i >> (chunk_base * LevelWidth))),
    .threshold_i(threshold_i),
    .base_id_i  (IdWidth'(chunk_base)),
    .best_o     (chunk_best)
  );

  // Strictly-higher replace: earlier chunks keep ties.
  always_comb begin
    merged = run_best;
    if (chunk_best.found && (!run_best.found || (chunk_best.level > run_best.level)))
      merged = chunk_best;
  end

  assign last_chunk     = (cnt == CntWidth'(NumChunks - 1));
  assign claim          = irq_valid_o & irq_ready_i;
  assign withdraw       = ~|((pending_i & enable_i) & (NumSrc'(1) << irq_id_o));
  assign unused_hi_bits = ^{merged.id, merged.level};

`ifdef CLIC_SCAN_PREEMPT_EN
  assign busy_o = (state == SCAN) || ((state == HOLD) && scan_en_i);
`else
  assign busy_o = (state == SCAN);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      run_best    <= '0;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      irq_level_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_en_i) begin
            state    <= SCAN;
            cnt      <= '0;
            run_best <= '0;
          end
        end
        SCAN: begin
          if (!scan_en_i) begin
            state    <= IDLE;
            cnt      <= '0;
            run_best <= '0;
          end else if (last_chunk) begin
            cnt      <= '0;
            run_best <= '0;
            if (merged.found) begin
              state       <= HOLD;
              irq_valid_o <= 1'b1;
              irq_id_o    <= merged.id[IdWidth-1:0];
              irq_level_o <= merged.level[LevelWidth-1:0];
            end
          end else begin
            cnt      <= cnt + 1'b1;
            run_best <= merged;
          end
        end
        HOLD: begin
          // Claim takes priority over withdraw and over any replacement.
          if (claim || withdraw) begin
            irq_valid_o <= 1'b0;
            state       <= scan_en_i ? SCAN : IDLE;
            cnt         <= '0;
            run_best    <= '0;
          end
`ifdef CLIC_SCAN_PREEMPT_EN
          else if (!scan_en_i) begin
            cnt      <= '0;
            run_best <= '0;
          end else if (last_chunk) begin
            cnt      <= '0;
            run_best <= '0;
            if (merged.found && (merged.level > MaxLevelWidth'(irq_level_o))) begin
              irq_id_o    <= merged.id[IdWidth-1:0];
              irq_level_o <= merged.level[LevelWidth-1:0];
            end
          end else begin
            cnt      <= cnt + 1'b1;
            run_best <= merged;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clic_irq_scanner.sv
// Directed self-checking bench for clic_irq_scanner (NumSrc=256, ScanWidth=16).
module tb_clic_irq_scanner;

  localparam int unsigned NumSrc     = 256;
  localparam int unsigned ScanWidth  = 16;
  localparam int unsigned LevelWidth = 8;
  localparam int unsigned IdWidth    = 8;

  logic                         clk = 1'b0;
  logic                         rst_i;
  logic                         scan_en_i;
  logic [NumSrc-1:0]            pending_i;
  logic [NumSrc-1:0]            enable_i;
  logic [NumSrc*LevelWidth-1:0] level_i;
  logic [LevelWidth-1:0]        threshold_i;
  logic                         irq_valid_o;
  logic [IdWidth-1:0]           irq_id_o;
  logic [LevelWidth-1:0]        irq_level_o;
  logic                         irq_ready_i;
  logic                         busy_o;

  int checks   = 0;
  int failures = 0;

`ifdef CLIC_SCAN_PREEMPT_EN
  localparam logic HoldBusy = 1'b1;
`else
  localparam logic HoldBusy = 1'b0;
`endif

  always #5 clk = ~clk;

  clic_irq_scanner #(
    .NumSrc    (NumSrc),
    .ScanWidth (ScanWidth),
    .LevelWidth(LevelWidth),
    .IdWidth   (IdWidth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .scan_en_i  (scan_en_i),
    .pending_i  (pending_i),
    .enable_i   (enable_i),
    .level_i    (level_i),
    .threshold_i(threshold_i),
    .irq_valid_o(irq_valid_o),
    .irq_id_o   (irq_id_o),
    .irq_level_o(irq_level_o),
    .irq_ready_i(irq_ready_i),
    .busy_o     (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    while (!irq_valid_o && (n < max_cycles)) begin
      tick();
      n++;
    end
  endtask

  task automatic set_src(input int k, input logic p, input logic e, input logic [7:0] l);
    pending_i[k] = p;
    enable_i[k]  = e;
    level_i[k*LevelWidth +: LevelWidth] = l;
  endtask

  task automatic run_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (irq_valid_o) seen = 1'b1;
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    int   n;
    logic dropped;

    rst_i       = 1'b1;
    scan_en_i   = 1'b0;
    pending_i   = '0;
    enable_i    = '0;
    level_i     = '0;
    threshold_i = '0;
    irq_ready_i = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(irq_valid_o), 0);
    check("rst_id",    32'(irq_id_o),    0);
    check("rst_level", 32'(irq_level_o), 0);
    check("rst_busy",  32'(busy_o),      0);
    rst_i = 1'b0;

    // Single winner: valid 17 edges after scan_en_i rises from IDLE.
    set_src(200, 1'b1, 1'b1, 8'd5);
    scan_en_i = 1'b1;
    wait_valid(40, n);
    check("single_latency", 32'(n), 17);
    check("single_valid", 32'(irq_valid_o), 1);
    check("single_id",    32'(irq_id_o),    200);
    check("single_level", 32'(irq_level_o), 5);
    check("hold_busy",    32'(busy_o),      32'(HoldBusy));
    repeat (3) tick();
    check("hold_stable_valid", 32'(irq_valid_o), 1);
    check("hold_stable_id",    32'(irq_id_o),    200);
    irq_ready_i    = 1'b1;
    scan_en_i      = 1'b0;
    pending_i[200] = 1'b0;
    tick();
    irq_ready_i = 1'b0;
    check("claim_valid_drop", 32'(irq_valid_o), 0);
    check("claim_idle_busy",  32'(busy_o),      0);

    // Tie rule within and across chunks.
    set_src(3,   1'b1, 1'b1, 8'd9);
    set_src(130, 1'b1, 1'b1, 8'd9);
    scan_en_i = 1'b1;
    wait_valid(40, n);
    check("tie_id",    32'(irq_id_o),    3);
    check("tie_level", 32'(irq_level_o), 9);
    irq_ready_i  = 1'b1;
    pending_i[3] = 1'b0;
    tick();
    irq_ready_i = 1'b0;
    check("claim_withdraw_valid", 32'(irq_valid_o), 0);
    check("claim_withdraw_busy",  32'(busy_o),      1);
    wait_valid(40, n);
    check("rescan_latency", 32'(n),        16);
    check("tie_next_id",    32'(irq_id_o), 130);
    irq_ready_i    = 1'b1;
    scan_en_i      = 1'b0;
    pending_i[130] = 1'b0;
    tick();
    irq_ready_i = 1'b0;
    check("tie_next_claim", 32'(irq_valid_o), 0);

    // Threshold: level must be strictly above.
    set_src(20, 1'b1, 1'b1, 8'd4);
    threshold_i = 8'd4;
    scan_en_i   = 1'b1;
    run_no_valid("thr_equal_no_valid", 40);
    check("thr_busy_scanning", 32'(busy_o), 1);
    threshold_i = 8'd3;
    wait_valid(40, n);
    check("thr_lower_valid", 32'(irq_valid_o), 1);
    check("thr_lower_id",    32'(irq_id_o),    20);
    check("thr_lower_level", 32'(irq_level_o), 4);

    // Withdraw by disabling the held source, then rescan.
    enable_i[20] = 1'b0;
    tick();
    check("withdraw_valid", 32'(irq_valid_o), 0);
    check("withdraw_busy",  32'(busy_o),      1);
    enable_i[20] = 1'b1;
    wait_valid(40, n);
    check("withdraw_rescan_latency", 32'(n),        16);
    check("withdraw_rescan_id",      32'(irq_id_o), 20);

    // scan_en_i low does not drop a held interrupt.
    scan_en_i = 1'b0;
    repeat (3) tick();
    check("hold_noscan_valid", 32'(irq_valid_o), 1);
    check("hold_noscan_id",    32'(irq_id_o),    20);
    check("hold_noscan_busy",  32'(busy_o),      0);
    enable_i[20] = 1'b0;
    tick();
    check("hold_withdraw_idle_valid", 32'(irq_valid_o), 0);
    check("hold_withdraw_idle_busy",  32'(busy_o),      0);

    // Reset mid-scan after chunk 1 (holding src 20) has been evaluated.
    enable_i[20] = 1'b1;
    scan_en_i    = 1'b1;
    repeat (3) tick();
    check("midscan_busy", 32'(busy_o), 1);
    rst_i         = 1'b1;
    pending_i[20] = 1'b0;
    tick();
    check("midrst_valid", 32'(irq_valid_o), 0);
    check("midrst_id",    32'(irq_id_o),    0);
    check("midrst_level", 32'(irq_level_o), 0);
    check("midrst_busy",  32'(busy_o),      0);
    rst_i = 1'b0;
    run_no_valid("rst_no_stale", 40);

    // Abort mid-scan after the same partial result.
    scan_en_i = 1'b0;
    tick();
    pending_i[20] = 1'b1;
    scan_en_i     = 1'b1;
    repeat (3) tick();
    scan_en_i = 1'b0;
    tick();
    check("abort_busy",  32'(busy_o),      0);
    check("abort_valid", 32'(irq_valid_o), 0);
    pending_i[20] = 1'b0;
    scan_en_i     = 1'b1;
    run_no_valid("abort_no_stale", 40);

    // Higher-level source arriving while another is held.
    scan_en_i = 1'b0;
    tick();
    threshold_i = 8'd0;
    set_src(10, 1'b1, 1'b1, 8'd2);
    scan_en_i = 1'b1;
    wait_valid(40, n);
    check("pre_hold_id",    32'(irq_id_o),    10);
    check("pre_hold_level", 32'(irq_level_o), 2);
    set_src(50, 1'b1, 1'b1, 8'd7);
    dropped = 1'b0;
    repeat (40) begin
      tick();
      if (!irq_valid_o) dropped = 1'b1;
    end
    check("pre_valid_steady", 32'(dropped), 0);
`ifdef CLIC_SCAN_PREEMPT_EN
    check("pre_new_id",    32'(irq_id_o),    50);
    check("pre_new_level", 32'(irq_level_o), 7);
`else
    check("pre_kept_id",    32'(irq_id_o),    10);
    check("pre_kept_level", 32'(irq_level_o), 2);
`endif
    irq_ready_i = 1'b1;
    scan_en_i   = 1'b0;
    pending_i   = '0;
    tick();
    irq_ready_i = 1'b0;
    check("final_claim_valid", 32'(irq_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
